// File: rtl/fir_stream_pkg.sv
// Shared types and helpers for the FIR output-side sample serializer.
package fir_stream_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } ser_state_e;

    // Width needed to hold a count of 0..depth inclusive.
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted when a pop happens on the same edge.
module sample_fifo
    import fir_stream_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned LVL_W = level_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             drop_o,
    output logic [LVL_W-1:0] level_o,
    output logic [LVL_W-1:0] level_next_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full, empty, do_push, do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (do_pop && !do_push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o       = mem_q[rd_ptr_q];
    assign empty_o      = empty;
    assign drop_o       = push_i && !do_push;
    assign level_o      = level_q;
    assign level_next_o = level_d;

endmodule

// File: rtl/fir_sample_serializer.sv
// Buffers FIR output samples and transmits each as a framed, MSB-first serial word.
module fir_sample_serializer
    import fir_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CLK_DIV    = 2,
    localparam int unsigned LVL_W = level_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clear_ovf,
    output logic                  sclk_out,
    output logic                  sdata_out,
    output logic                  frame_out,
    output logic                  busy,
    output logic                  overflow,
    output logic [LVL_W-1:0]      fifo_level
);

    localparam int unsigned BIT_W = $clog2(DATA_WIDTH);
    localparam int unsigned PH_W  = $clog2(CLK_DIV);

    ser_state_e            state_q, state_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  sclk_q, sclk_d, sdata_q, sdata_d, frame_q, frame_d;
    logic                  busy_q, busy_d, ovf_q, ovf_d;
    logic                  pop_c;

    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_empty, fifo_drop;
    logic [LVL_W-1:0]      fifo_level_q, fifo_level_next;

    sample_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (valid_in),
        .data_i       (data_in),
        .pop_i        (pop_c),
        .data_o       (fifo_data),
        .empty_o      (fifo_empty),
        .drop_o       (fifo_drop),
        .level_o      (fifo_level_q),
        .level_next_o (fifo_level_next)
    );

    // Next-state and next-output logic; outputs derive from post-edge position.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        shreg_d = shreg_q;
        pop_c   = 1'b0;
        ovf_d   = fifo_drop ? 1'b1 : (clear_ovf ? 1'b0 : ovf_q);

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    shreg_d = fifo_data;
                    state_d = ST_SHIFT;
                    bit_d   = '0;
                    phase_d = '0;
                end
            end
            ST_SHIFT: begin
                if (phase_q == PH_W'(CLK_DIV - 1)) begin
                    phase_d = '0;
                    if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                        state_d = ST_GAP;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_GAP: begin
                if (phase_q == PH_W'(CLK_DIV - 1)) begin
                    phase_d = '0;
                    if (!fifo_empty) begin
                        pop_c   = 1'b1;
                        shreg_d = fifo_data;
                        state_d = ST_SHIFT;
                        bit_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase

        frame_d = (state_d == ST_SHIFT);
        sclk_d  = frame_d && (phase_d >= PH_W'(CLK_DIV / 2));
        sdata_d = frame_d && shreg_d[DATA_WIDTH-1];
        busy_d  = (state_d != ST_IDLE) || (fifo_level_next != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            phase_q <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
            frame_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            sdata_q <= sdata_d;
            frame_q <= frame_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sclk_out   = sclk_q;
    assign sdata_out  = sdata_q;
    assign frame_out  = frame_q;
    assign busy       = busy_q;
    assign overflow   = ovf_q;
    assign fifo_level = fifo_level_q;

endmodule

// File: tb/tb_fir_sample_serializer.sv
// Directed bench for fir_sample_serializer (DATA_WIDTH=16, FIFO_DEPTH=4, CLK_DIV=2).
module tb_fir_sample_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [15:0] data_in;
    logic        clear_ovf;
    logic        sclk_out, sdata_out, frame_out, busy, overflow;
    logic [2:0]  fifo_level;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    fir_sample_serializer #(
        .DATA_WIDTH (16),
        .FIFO_DEPTH (4),
        .CLK_DIV    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .clear_ovf  (clear_ovf),
        .sclk_out   (sclk_out),
        .sdata_out  (sdata_out),
        .frame_out  (frame_out),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame receiver: samples sdata on sclk rising edges, logs words, lengths and start cycles.
    logic [15:0] words_q [$];
    int          len_q   [$];
    int          start_q [$];
    logic [15:0] rx_word;
    int          rx_len;
    logic        prev_sclk = 1'b0;
    logic        prev_frame = 1'b0;
    int          peak_level = 0;

    always @(negedge clk) begin
        if (int'(fifo_level) > peak_level) peak_level = int'(fifo_level);
        if (frame_out === 1'b1) begin
            if (prev_frame !== 1'b1) begin
                start_q.push_back(cyc);
                rx_len  = 0;
                rx_word = '0;
            end
            rx_len++;
            if (sclk_out === 1'b1 && prev_sclk !== 1'b1) rx_word = {rx_word[14:0], sdata_out};
        end else if (prev_frame === 1'b1) begin
            words_q.push_back(rx_word);
            len_q.push_back(rx_len);
        end
        prev_frame = frame_out;
        prev_sclk  = sclk_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        words_q.delete();
        len_q.delete();
        start_q.delete();
        peak_level = 0;
    endtask

    task automatic wait_idle(input int max, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            n++;
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Pushes words on consecutive edges; ends with valid_in low after the last push edge.
    task automatic push_burst(input logic [15:0] w [], input int cnt);
        for (int i = 0; i < cnt; i++) begin
            valid_in = 1'b1;
            data_in  = w[i];
            tick();
        end
        valid_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_in = 1'b0; data_in = '0; clear_ovf = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({sclk_out, sdata_out, frame_out, busy, overflow, fifo_level} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {sclk_out, sdata_out, frame_out, busy, overflow, fifo_level});
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || frame_out !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: busy=%b frame=%b expected 0 0", busy, frame_out);
        end
    endtask

    task automatic test_single();
        int n; bit ok; int k;
        clear_mon();
        valid_in = 1'b1; data_in = 16'hA5C3;
        tick();
        k = cyc;
        valid_in = 1'b0;
        n_cmp++;
        if (fifo_level !== 3'd1 || frame_out !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL single_capture: level=%0d frame=%b busy=%b expected 1 0 1", fifo_level, frame_out, busy);
        end
        tick();
        n_cmp++;
        if (frame_out !== 1'b1 || fifo_level !== 3'd0 || sclk_out !== 1'b0 || sdata_out !== 1'b1) begin
            n_bad++;
            $display("FAIL single_first_bit: frame=%b level=%0d sclk=%b sdata=%b expected 1 0 0 1",
                     frame_out, fifo_level, sclk_out, sdata_out);
        end
        wait_idle(200, n, ok);
        n_cmp++;
        if (!ok || n !== 34) begin
            n_bad++;
            $display("FAIL single_busy_drop: cycles=%0d ok=%0d expected 34", n, ok);
        end
        n_cmp++;
        if (words_q.size() !== 1 || start_q.size() !== 1) begin
            n_bad++;
            $display("FAIL single_frame_count: got %0d expected 1", words_q.size());
        end else begin
            n_cmp++;
            if (words_q[0] !== 16'hA5C3 || len_q[0] !== 32 || start_q[0] !== k + 1) begin
                n_bad++;
                $display("FAIL single_word: word=%h len=%0d start=%0d expected a5c3 32 %0d",
                         words_q[0], len_q[0], start_q[0], k + 1);
            end
        end
    endtask

    task automatic test_four_words();
        logic [15:0] w [] = '{16'h0001, 16'h8000, 16'hFFFF, 16'h1234};
        int n; bit ok;
        clear_mon();
        push_burst(w, 4);
        wait_idle(400, n, ok);
        n_cmp++;
        if (!ok || words_q.size() !== 4) begin
            n_bad++;
            $display("FAIL four_frame_count: got %0d ok=%0d expected 4", words_q.size(), ok);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (words_q[i] !== w[i] || len_q[i] !== 32) begin
                    n_bad++;
                    $display("FAIL four_word%0d: got %h len %0d expected %h len 32", i, words_q[i], len_q[i], w[i]);
                end
            end
            for (int i = 1; i < 4; i++) begin
                n_cmp++;
                if (start_q[i] - start_q[i-1] !== 34) begin
                    n_bad++;
                    $display("FAIL four_period%0d: got %0d expected 34", i, start_q[i] - start_q[i-1]);
                end
            end
        end
        n_cmp++;
        if (overflow !== 1'b0 || peak_level !== 3) begin
            n_bad++;
            $display("FAIL four_ovf_peak: overflow=%b peak=%0d expected 0 3", overflow, peak_level);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] w [] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
        int n; bit ok;
        clear_mon();
        push_burst(w, 5);
        n_cmp++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_full: level=%0d overflow=%b expected 4 0", fifo_level, overflow);
        end
        valid_in = 1'b1; data_in = w[5];
        tick();
        valid_in = 1'b0;
        n_cmp++;
        if (overflow !== 1'b1 || fifo_level !== 3'd4) begin
            n_bad++;
            $display("FAIL ovf_set: overflow=%b level=%0d expected 1 4", overflow, fifo_level);
        end
        wait_idle(400, n, ok);
        n_cmp++;
        if (!ok || words_q.size() !== 5 || overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_frames: got %0d overflow=%b expected 5 1", words_q.size(), overflow);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (words_q[i] !== w[i]) begin
                    n_bad++;
                    $display("FAIL ovf_word%0d: got %h expected %h", i, words_q[i], w[i]);
                end
            end
        end
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clear: got %b expected 0", overflow);
        end
    endtask

    task automatic test_push_at_full_pop();
        logic [15:0] w [] = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005, 16'hA006};
        int n; bit ok;
        clear_mon();
        push_burst(w, 5);
        for (int i = 0; i < 30; i++) tick();
        n_cmp++;
        if (fifo_level !== 3'd4 || frame_out !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL simul_pre: level=%0d frame=%b busy=%b expected 4 0 1", fifo_level, frame_out, busy);
        end
        valid_in = 1'b1; data_in = w[5];
        tick();
        valid_in = 1'b0;
        n_cmp++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0 || frame_out !== 1'b1) begin
            n_bad++;
            $display("FAIL simul_push_pop: level=%0d overflow=%b frame=%b expected 4 0 1",
                     fifo_level, overflow, frame_out);
        end
        wait_idle(500, n, ok);
        n_cmp++;
        if (!ok || words_q.size() !== 6) begin
            n_bad++;
            $display("FAIL simul_frames: got %0d ok=%0d expected 6", words_q.size(), ok);
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (words_q[i] !== w[i]) begin
                    n_bad++;
                    $display("FAIL simul_word%0d: got %h expected %h", i, words_q[i], w[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] w [] = '{16'hBEEF, 16'hCAFE, 16'hF00D};
        clear_mon();
        push_burst(w, 3);
        for (int i = 0; i < 8; i++) tick();
        n_cmp++;
        if (frame_out !== 1'b1 || fifo_level !== 3'd2) begin
            n_bad++;
            $display("FAIL midrst_pre: frame=%b level=%0d expected 1 2", frame_out, fifo_level);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({sclk_out, sdata_out, frame_out, busy, overflow, fifo_level} !== 8'h00) begin
            n_bad++;
            $display("FAIL midrst_outputs: got %b expected 00000000",
                     {sclk_out, sdata_out, frame_out, busy, overflow, fifo_level});
        end
        rst = 1'b0;
        tick();
        start_q.delete();
        for (int i = 0; i < 100; i++) tick();
        n_cmp++;
        if (start_q.size() !== 0 || busy !== 1'b0 || fifo_level !== 3'd0) begin
            n_bad++;
            $display("FAIL midrst_quiet: frames=%0d busy=%b level=%0d expected 0 0 0",
                     start_q.size(), busy, fifo_level);
        end
    endtask

    task automatic test_clear_vs_drop();
        logic [15:0] w [] = '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 16'h0E0E, 16'h0F0F};
        int n; bit ok;
        clear_mon();
        push_burst(w, 5);
        valid_in = 1'b1; data_in = w[5]; clear_ovf = 1'b1;
        tick();
        valid_in = 1'b0; clear_ovf = 1'b0;
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_drop_same: got %b expected 1", overflow);
        end
        tick();
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_drop_sticky: got %b expected 1", overflow);
        end
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_drop_clear: got %b expected 0", overflow);
        end
        wait_idle(400, n, ok);
        n_cmp++;
        if (!ok || words_q.size() !== 5) begin
            n_bad++;
            $display("FAIL clr_drop_frames: got %0d ok=%0d expected 5", words_q.size(), ok);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_four_words();
        test_overflow();
        test_push_at_full_pop();
        test_reset_mid_frame();
        test_clear_vs_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
